instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the control unit.
- Owns the program counter and issues word fetches to instruction memory over a req/ready handshake.
- Presents the fetched instruction, plus its opcode [31:26] and func [5:0] fields, to decode.
- Consumes the control unit's halted/branch/jump/jump_register decisions to select the next PC: multi-cycle, single-issue, no delay slot.

---
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a req/ready
// handshake and picks the next PC from the control unit's redirect decisions.
//
// state | meaning
// FETCH | request word at pc (first cycle after reset only raises imem_req)
// WAIT  | request outstanding, address held until imem_ready
// VALID | inst presented to decode, retires when stall is low
// HALT  | SYSCALL retired, idle until reset
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_data,
  output logic [31:0]           inst,
  output logic [5:0]            opcode,
  output logic [5:0]            func,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  stall,
  input  logic                  halted,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  jump_register,
  input  logic [31:0]           rs_data,
  output logic [31:0]           retired_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK   = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] REGION_MASK = ~ADDR_WIDTH'(32'h0FFF_FFFF);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] jr_target;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [31:0]           branch_offset;

  assign imem_addr = pc;
  assign opcode    = inst[31:26];
  assign func      = inst[5:0];

  assign pc_plus4      = pc + ADDR_WIDTH'(4);
  assign branch_offset = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign branch_target = pc_plus4 + ADDR_WIDTH'(branch_offset);
  assign jump_target   = (pc_plus4 & REGION_MASK) | ADDR_WIDTH'({inst[25:0], 2'b00});
  assign jr_target     = ADDR_WIDTH'(rs_data) & WORD_MASK;

  always_comb begin
    next_pc = pc_plus4;
    if (jump_register) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      pc            <= ADDR_WIDTH'(RESET_PC);
      inst          <= '0;
      inst_valid    <= 1'b0;
      imem_req      <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // Right after reset the request is not yet visible, so ready cannot apply.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            inst       <= imem_data;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= S_VALID;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ready) begin
            inst       <= imem_data;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            retired_count <= retired_count + 32'd1;
            inst_valid    <= 1'b0;
            if (halted) begin
              state <= S_HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          inst_valid <= 1'b0;
          imem_req   <= 1'b0;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle-level reference of the fetch
// rules is checked every cycle, plus literal checks on fetch order and timing.
module tb_instruction_fetch_unit;
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        inst_valid;
  logic [31:0] pc;
  logic        stall = 1'b0;
  logic        halted = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jump_register = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .inst(inst), .opcode(opcode),
    .func(func), .inst_valid(inst_valid), .pc(pc), .stall(stall), .halted(halted),
    .branch(branch), .jump(jump), .jump_register(jump_register), .rs_data(rs_data),
    .retired_count(retired_count)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // program image and per-address control-unit decisions (index = addr[9:2])
  logic [31:0] mem [256];
  int          wait_tab [256];
  bit          br_tab [256];
  bit          j_tab [256];
  bit          jr_tab [256];
  bit          halt_tab [256];
  logic [31:0] rs_tab [256];
  int          stall_left [256];
  int          wcnt = 0;

  // reference state: what the outputs must show after the next edge
  bit          live = 1'b0;
  bit          e_req, e_valid, e_halt;
  logic [31:0] e_pc, e_inst, e_rc;

  word_q_t fetch_q, fstart_q, run_q, vrise_q, vrun_q;
  bit      prev_req, prev_valid;
  int      cur_run, vcur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tchk(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s cycle=%0d got=timeout expected=event", name, cyc);
    end
  endtask

  function automatic logic [31:0] qget(input word_q_t q, input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] i,
                                             input bit b, input bit j, input bit jr,
                                             input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (jr) return rs - (rs % 32'd4);
    if (j) return (seq / 32'h1000_0000) * 32'h1000_0000 + (i % 32'h0400_0000) * 32'd4;
    if (b) begin
      off = int'($signed(i[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic compare();
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    chk("pc", pc, e_pc);
    chk("imem_addr", imem_addr, e_pc);
    chk("inst", inst, e_inst);
    chk("opcode", {26'b0, opcode}, {26'b0, e_inst[31:26]});
    chk("func", {26'b0, func}, {26'b0, e_inst[5:0]});
    chk("retired_count", retired_count, e_rc);
  endtask

  task automatic observe();
    if (imem_req === 1'b1 && !prev_req) begin
      fetch_q.push_back(imem_addr);
      fstart_q.push_back(32'(cyc));
    end
    if (imem_req === 1'b1) cur_run++;
    else if (prev_req) begin run_q.push_back(32'(cur_run)); cur_run = 0; end
    if (inst_valid === 1'b1 && !prev_valid) vrise_q.push_back(32'(cyc));
    if (inst_valid === 1'b1) vcur++;
    else if (prev_valid) begin vrun_q.push_back(32'(vcur)); vcur = 0; end
    prev_req   = (imem_req === 1'b1);
    prev_valid = (inst_valid === 1'b1);
  endtask

  task automatic step(input bit r);
    int idx;
    int ai;
    @(negedge clk);
    cyc++;
    if (live) compare();
    observe();
    reset = r;
    idx = int'(e_pc[9:2]);
    // memory shares reset and answers only real requests
    if (r) begin
      wcnt = 0; imem_ready = 1'b0;
    end else if (imem_req === 1'b1) begin
      ai = int'(imem_addr[9:2]);
      if (wcnt >= wait_tab[ai]) begin
        imem_ready = 1'b1; imem_data = mem[ai]; wcnt = 0;
      end else begin
        imem_ready = 1'b0; imem_data = 32'hDEAD_BEEF; wcnt++;
      end
    end else begin
      imem_ready = 1'b0; imem_data = 32'hDEAD_BEEF; wcnt = 0;
    end
    if (e_valid && !e_halt) begin
      if (stall_left[idx] > 0) begin stall = 1'b1; stall_left[idx]--; end
      else stall = 1'b0;
      branch = br_tab[idx]; jump = j_tab[idx]; jump_register = jr_tab[idx];
      halted = halt_tab[idx]; rs_data = rs_tab[idx];
    end else begin
      {stall, branch, jump, jump_register, halted} = 5'($urandom);
      rs_data = $urandom;
    end
    if (r) begin
      e_req = 0; e_valid = 0; e_halt = 0; e_pc = 32'h0; e_inst = '0; e_rc = '0;
      live = 1'b1;
    end else if (e_halt) begin
      e_req = 0;
    end else if (e_valid) begin
      if (!stall) begin
        e_rc++;
        e_valid = 0;
        if (halted) e_halt = 1;
        else begin
          e_pc = model_next(e_pc, e_inst, branch, jump, jump_register, rs_data);
          e_req = 1;
        end
      end
    end else if (!e_req) begin
      e_req = 1;
    end else if (imem_ready) begin
      e_inst = mem[idx]; e_valid = 1; e_req = 0;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0; wait_tab[i] = 0; br_tab[i] = 0; j_tab[i] = 0; jr_tab[i] = 0;
      halt_tab[i] = 0; rs_tab[i] = 32'h0; stall_left[i] = 0;
    end
  endtask

  task automatic clear_logs();
    fetch_q.delete(); fstart_q.delete(); run_q.delete(); vrise_q.delete(); vrun_q.delete();
    prev_req = 0; prev_valid = 0; cur_run = 0; vcur = 0;
  endtask

  task automatic run_to_halt(input string name);
    int n;
    n = 0;
    while (!e_halt && n < 100) begin step(1'b0); n++; end
    tchk(name, e_halt);
    for (int k = 0; k < 3; k++) step(1'b0);
  endtask

  initial begin
    int n;
    int reqs;

    // sequential fetch, zero-wait memory, SYSCALL at 0x8
    clear_prog();
    mem[0] = 32'h2401_0001; mem[1] = 32'h2402_0002; mem[2] = 32'h0000_000C; halt_tab[2] = 1;
    step(1'b1); clear_logs();
    run_to_halt("t1_halt_timeout");
    reqs = 0;
    for (int k = 0; k < 20; k++) begin step(1'b0); if (imem_req !== 1'b0) reqs++; end
    chk("t1_halt_req_cycles", 32'(reqs), 32'd0);
    chk("t1_nfetch", 32'(fetch_q.size()), 32'd3);
    chk("t1_fetch0", qget(fetch_q, 0), 32'h0);
    chk("t1_fetch1", qget(fetch_q, 1), 32'h4);
    chk("t1_fetch2", qget(fetch_q, 2), 32'h8);
    chk("t1_valid_spacing", qget(vrise_q, 1) - qget(vrise_q, 0), 32'd2);
    chk("t1_retired", retired_count, 32'd3);
    chk("t1_pc", pc, 32'h8);
    chk("t1_inst", inst, 32'h0000_000C);
    chk("t1_valid_low", {31'b0, inst_valid}, 32'd0);

    // reset from HALT, 3 wait states on the fetch at 0x4
    wait_tab[1] = 3;
    step(1'b1); clear_logs();
    run_to_halt("t2_halt_timeout");
    chk("t2_fetch0", qget(fetch_q, 0), 32'h0);
    chk("t2_fetch1", qget(fetch_q, 1), 32'h4);
    chk("t2_req_run0", qget(run_q, 0), 32'd1);
    chk("t2_req_run1", qget(run_q, 1), 32'd4);
    chk("t2_valid_after_ready", qget(vrise_q, 1) - qget(fstart_q, 1), 32'd4);
    chk("t2_retired", retired_count, 32'd3);

    // redirects: J, BEQ backwards, J, J, JR misaligned, JR beating branch, SYSCALL
    clear_prog();
    mem[0]   = 32'h0800_0004; j_tab[0] = 1;
    mem[4]   = 32'h1000_FFFC; br_tab[4] = 1;
    mem[1]   = 32'h0800_0008; j_tab[1] = 1;
    mem[8]   = 32'h0800_0040; j_tab[8] = 1;
    mem[64]  = 32'h00A0_0008; jr_tab[64] = 1; rs_tab[64] = 32'h0000_0203;
    mem[128] = 32'h1000_0010; jr_tab[128] = 1; br_tab[128] = 1; rs_tab[128] = 32'h0000_0030;
    mem[12]  = 32'h0000_000C; halt_tab[12] = 1;
    step(1'b1); clear_logs();
    run_to_halt("t3_halt_timeout");
    chk("t3_nfetch", 32'(fetch_q.size()), 32'd7);
    chk("t3_fetch_beq_target", qget(fetch_q, 2), 32'h0000_0004);
    chk("t3_fetch_j_target", qget(fetch_q, 4), 32'h0000_0100);
    chk("t3_fetch_jr_target", qget(fetch_q, 5), 32'h0000_0200);
    chk("t3_fetch_jr_wins", qget(fetch_q, 6), 32'h0000_0030);
    chk("t3_retired", retired_count, 32'd7);
    chk("t3_pc", pc, 32'h0000_0030);

    // stall 5 cycles with branch held, then JR to top of memory and wrap to 0
    clear_prog();
    mem[0]   = 32'h1000_0003; br_tab[0] = 1; stall_left[0] = 5;
    mem[4]   = 32'h00A0_0008; jr_tab[4] = 1; rs_tab[4] = 32'hFFFF_FFFF;
    mem[255] = 32'h2403_0003;
    step(1'b1); clear_logs();
    n = 0;
    while (e_rc < 32'd4 && n < 100) begin step(1'b0); n++; end
    tchk("t4_retire_timeout", e_rc >= 32'd4);
    step(1'b0); step(1'b0);
    chk("t4_valid_run", qget(vrun_q, 0), 32'd6);
    chk("t4_req_after_stall", qget(fstart_q, 1) - qget(vrise_q, 0), 32'd6);
    chk("t4_fetch_branch", qget(fetch_q, 1), 32'h0000_0010);
    chk("t4_fetch_top", qget(fetch_q, 2), 32'hFFFF_FFFC);
    chk("t4_fetch_wrap", qget(fetch_q, 3), 32'h0000_0000);

    // reset while waiting on the fetch at 0x14
    clear_prog();
    mem[0] = 32'h0800_0005; j_tab[0] = 1;
    mem[5] = 32'h2404_0004; wait_tab[5] = 10;
    step(1'b1); clear_logs();
    n = 0;
    while (!(e_req && e_pc == 32'h14) && n < 30) begin step(1'b0); n++; end
    tchk("t5_reach_wait", e_req && e_pc == 32'h14);
    step(1'b0); step(1'b0);
    chk("t5_waiting_req", {31'b0, imem_req}, 32'd1);
    chk("t5_waiting_addr", imem_addr, 32'h14);
    step(1'b1);
    step(1'b0);
    chk("t5_rst_req", {31'b0, imem_req}, 32'd0);
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t5_rst_retired", retired_count, 32'd0);
    step(1'b0);
    chk("t5_refetch_req", {31'b0, imem_req}, 32'd1);
    chk("t5_refetch_addr", imem_addr, 32'h0);
    for (int k = 0; k < 6; k++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
